// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle restoring integer divider, one quotient bit per
//            clock, signed/unsigned per operation, start/busy/done handshake,
//            divide-by-zero and signed-overflow flags.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] c_int_min = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_all_one = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] c_iters   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_dvs_mag;
  logic [WIDTH-1:0]   r_rem_acc;
  logic [WIDTH-1:0]   r_q_acc;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;

  // Operand sign/magnitude split; MIN maps to the unsigned value 2**(WIDTH-1)
  always_comb begin
    w_dvd_neg = r_signed & r_dvd[WIDTH-1];
    w_dvs_neg = r_signed & r_dvs[WIDTH-1];
    w_dvd_mag = w_dvd_neg ? (-r_dvd) : r_dvd;
    w_dvs_mag = w_dvs_neg ? (-r_dvs) : r_dvs;
  end

  // One restoring step: the shifted partial remainder is WIDTH+1 bits wide;
  // if its top bit is set it certainly exceeds the divisor, and the true
  // difference always fits in WIDTH bits, so a modular subtract suffices.
  always_comb begin
    w_shift = {r_rem_acc, r_q_acc[WIDTH-1]};
    w_ge    = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_dvs_mag);
    w_sub   = w_shift[WIDTH-1:0] - r_dvs_mag;
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_dvs_mag   <= '0;
      r_rem_acc   <= '0;
      r_q_acc     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // done trails the DONE state by one register stage
      done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_signed    <= signed_op;
            r_dvd       <= dividend;
            r_dvs       <= divisor;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_PREP;
          end
        end
        S_PREP: begin
          r_neg_q <= w_dvd_neg ^ w_dvs_neg;
          r_neg_r <= w_dvd_neg;
          if (r_dvs == '0) begin
            r_div0  <= 1'b1;
            r_state <= S_FIX;
          end else begin
            r_div0    <= 1'b0;
            r_dvs_mag <= w_dvs_mag;
            r_rem_acc <= '0;
            r_q_acc   <= w_dvd_mag;
            r_cnt     <= c_iters;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_q_acc   <= {r_q_acc[WIDTH-2:0], w_ge};
          r_cnt     <= r_cnt - 1'b1;
          if (r_cnt == c_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_div0) begin
            quot        <= c_all_one;
            rem         <= r_dvd;
            div_by_zero <= 1'b1;
          end else begin
            quot     <= r_neg_q ? (-r_q_acc) : r_q_acc;
            rem      <= r_neg_r ? (-r_rem_acc) : r_rem_acc;
            // MIN / -1 wraps back to MIN through the negation above
            overflow <= r_signed && (r_dvd == c_int_min) && (r_dvs == c_all_one);
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
